// File: rtl/dda_pkg.sv
// Shared definitions for the DDA move engine.
//   - state_e     : engine sequencing states
//   - rollback()  : accumulator rollback constant 2^(width-1) - 101
//   - entry_width : bit width of one buffered segment
// Segment entry layout, MSB to LSB: {incinc, increment, duration, dir},
// where each per-axis field packs axis 0 in its LSBs.
package dda_pkg;

  localparam int unsigned MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Caller truncates the result to its own accumulator width.
  function automatic logic [MAX_WIDTH-1:0] rollback(input int unsigned width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(101);
  endfunction

  function automatic int unsigned entry_width(input int unsigned num_axes,
                                              input int unsigned width);
    return num_axes + width + 2 * num_axes * width;
  endfunction

endpackage

// File: rtl/dda_move_if.sv
// Segment write channel from the command decoder into the move engine.
//   move_valid/move_ready : write handshake (write when both high)
//   move_dir              : per-axis direction, 1 = positive
//   move_duration         : DDA ticks in the segment
//   move_increment/incinc : signed per-axis increment and increment-increment
interface dda_move_if #(
  parameter int unsigned NUM_AXES = 1,
  parameter int unsigned WIDTH    = 64
);
  logic                      move_valid;
  logic                      move_ready;
  logic [NUM_AXES-1:0]       move_dir;
  logic [WIDTH-1:0]          move_duration;
  logic [NUM_AXES*WIDTH-1:0] move_increment;
  logic [NUM_AXES*WIDTH-1:0] move_incinc;

  modport master (
    output move_valid, move_dir, move_duration, move_increment, move_incinc,
    input  move_ready
  );

  modport slave (
    input  move_valid, move_dir, move_duration, move_increment, move_incinc,
    output move_ready
  );
endinterface

// File: rtl/move_fifo.sv
// Circular segment buffer with BUFFER_BITS+1 bit pointers.
//   clk, rst_n      : clock, async active-low reset
//   flush_i         : clear pointers; wins over a simultaneous write
//   wr_en_i/wr_data_i : write request (ignored while full)
//   rd_en_i         : pop head (ignored while empty)
//   rd_data_o       : current head entry
//   full_o/empty_o  : registered flags
//   empty_next_c_o  : empty flag as it will be next cycle
module move_fifo
  import dda_pkg::*;
#(
  parameter int unsigned BUFFER_BITS = 2,
  parameter int unsigned ENTRY_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               empty_next_c_o
);
  localparam int unsigned DEPTH = 1 << BUFFER_BITS;
  localparam int unsigned PTR_W = BUFFER_BITS + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               full_q, full_d, empty_q, empty_d;
  logic               wr_fire;

  assign wr_fire = wr_en_i && !full_q && !flush_i;

  // Pointer advance; a push and a pop in one cycle both take effect.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire)             wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_i && !empty_q) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    empty_d = (rd_ptr_d == wr_ptr_d);
    full_d  = (rd_ptr_d[BUFFER_BITS] != wr_ptr_d[BUFFER_BITS]) &&
              (rd_ptr_d[BUFFER_BITS-1:0] == wr_ptr_d[BUFFER_BITS-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[BUFFER_BITS-1:0]] <= wr_data_i;
  end

  assign rd_data_o      = mem_q[rd_ptr_q[BUFFER_BITS-1:0]];
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign empty_next_c_o = empty_d;
endmodule

// File: rtl/dda_move_engine.sv
// Multi-axis coordinated-move engine: buffers segments and executes them
// back-to-back with a clock-divided second-order DDA.
//   CLK, resetn   : clock, async active-low reset
//   move_if       : segment write channel (slave side)
//   clock_divisor : tick period is divisor+1 cycles, 0 behaves as 1
//   abort         : synchronous flush of buffer, accumulators and state
//   step, dir     : per-axis one-cycle step pulse and segment direction
//   position      : signed per-axis step count, axis 0 in the LSBs
//   busy, buffer_empty, underflow : status (underflow is sticky)
module dda_move_engine
  import dda_pkg::*;
#(
  parameter int unsigned NUM_AXES    = 1,
  parameter int unsigned BUFFER_BITS = 2,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DIV_WIDTH   = 8
) (
  input  logic                      CLK,
  input  logic                      resetn,
  dda_move_if.slave                 move_if,
  input  logic [DIV_WIDTH-1:0]      clock_divisor,
  input  logic                      abort,
  output logic [NUM_AXES-1:0]       step,
  output logic [NUM_AXES-1:0]       dir,
  output logic [NUM_AXES*WIDTH-1:0] position,
  output logic                      busy,
  output logic                      buffer_empty,
  output logic                      underflow
);
  localparam int unsigned    ENTRY_W  = entry_width(NUM_AXES, WIDTH);
  localparam logic [WIDTH-1:0] ROLLBACK = WIDTH'(rollback(WIDTH));

  typedef struct packed {
    logic [NUM_AXES*WIDTH-1:0] incinc;
    logic [NUM_AXES*WIDTH-1:0] increment;
    logic [WIDTH-1:0]          duration;
    logic [NUM_AXES-1:0]       dir;
  } entry_t;

  state_e               state_q, state_d;
  logic [NUM_AXES-1:0]  dir_q, dir_d;
  logic [WIDTH-1:0]     tickdown_q, tickdown_d;
  logic [DIV_WIDTH-1:0] clkaccum_q, clkaccum_d, eff_div;
  logic                 underflow_q, underflow_d;
  logic                 tick, load;
  logic [NUM_AXES-1:0]  inc_nz;
  entry_t               wr_entry, head;
  logic [ENTRY_W-1:0]   rd_data;
  logic                 fifo_full, fifo_empty, fifo_empty_next;

  assign wr_entry.incinc    = move_if.move_incinc;
  assign wr_entry.increment = move_if.move_increment;
  assign wr_entry.duration  = move_if.move_duration;
  assign wr_entry.dir       = move_if.move_dir;
  assign head               = entry_t'(rd_data);

  move_fifo #(
    .BUFFER_BITS (BUFFER_BITS),
    .ENTRY_W     (ENTRY_W)
  ) u_fifo (
    .clk            (CLK),
    .rst_n          (resetn),
    .flush_i        (abort),
    .wr_en_i        (move_if.move_valid),
    .wr_data_i      (ENTRY_W'(wr_entry)),
    .rd_en_i        (load),
    .rd_data_o      (rd_data),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .empty_next_c_o (fifo_empty_next)
  );

  assign eff_div = (clock_divisor == '0) ? DIV_WIDTH'(1) : clock_divisor;
  assign tick    = (state_q == ST_RUN) && (clkaccum_q == '0);
  assign load    = (state_q == ST_LOAD);

  // Sequencing: "more buffered" looks at next-cycle occupancy so the
  // following LOAD lands directly after the last tick.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    tickdown_d  = tickdown_q;
    clkaccum_d  = clkaccum_q;
    underflow_d = underflow_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty_next) state_d = ST_LOAD;
      ST_LOAD: begin
        dir_d      = head.dir;
        tickdown_d = head.duration;
        clkaccum_d = eff_div;
        if (head.duration == '0) begin
          state_d = fifo_empty_next ? ST_IDLE : ST_LOAD;
          if (fifo_empty_next && (|inc_nz)) underflow_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          clkaccum_d = eff_div;
          tickdown_d = tickdown_q - WIDTH'(1);
          if (tickdown_q == WIDTH'(1)) begin
            state_d = fifo_empty_next ? ST_IDLE : ST_LOAD;
            if (fifo_empty_next && (|inc_nz)) underflow_d = 1'b1;
          end
        end else begin
          clkaccum_d = clkaccum_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      tickdown_d  = '0;
      clkaccum_d  = '0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dir_q       <= '0;
      tickdown_q  <= '0;
      clkaccum_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      tickdown_q  <= tickdown_d;
      clkaccum_q  <= clkaccum_d;
      underflow_q <= underflow_d;
    end
  end

  // Per-axis DDA: accumulate on ticks, roll back one step on other cycles.
  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, incinc_q, incinc_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             step_q, step_d;

    always_comb begin
      acc_d    = acc_q;
      inc_d    = inc_q;
      incinc_d = incinc_q;
      pos_d    = pos_q;
      step_d   = 1'b0;
      if (load) begin
        inc_d    = head.increment[i*WIDTH +: WIDTH];
        incinc_d = head.incinc[i*WIDTH +: WIDTH];
      end
      if (tick) begin
        acc_d = acc_q + inc_q;
        inc_d = inc_q + incinc_q;
      end else if (!acc_q[WIDTH-1] && (acc_q != '0)) begin
        acc_d  = acc_q - ROLLBACK;
        step_d = 1'b1;
        pos_d  = dir_q[i] ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
      end
      if (abort) begin
        acc_d  = '0;
        inc_d  = '0;
        step_d = 1'b0;
        pos_d  = pos_q;
      end
    end

    always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
        acc_q    <= '0;
        inc_q    <= '0;
        incinc_q <= '0;
        pos_q    <= '0;
        step_q   <= 1'b0;
      end else begin
        acc_q    <= acc_d;
        inc_q    <= inc_d;
        incinc_q <= incinc_d;
        pos_q    <= pos_d;
        step_q   <= step_d;
      end
    end

    assign inc_nz[i]                  = |inc_d;
    assign step[i]                    = step_q;
    assign position[i*WIDTH +: WIDTH] = pos_q;
  end

  assign dir              = dir_q;
  assign busy             = (state_q != ST_IDLE);
  assign buffer_empty     = fifo_empty;
  assign underflow        = underflow_q;
  assign move_if.move_ready = !fifo_full;
endmodule

// File: tb/tb_dda_move_engine.sv
// Scoreboard bench for dda_move_engine (2 axes, depth 4, 64-bit).
// Stimulus pushes the expected position after every step per axis; a
// monitor pops one entry per observed step pulse and compares.
module tb_dda_move_engine;
  localparam longint R  = 64'h7FFF_FFFF_FFFF_FF9B;
  localparam longint R2 = 64'h3FFF_FFFF_FFFF_FFCD;

  typedef struct {
    longint pos;
    int     gap;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   div = 8'd1;
  logic         abort = 1'b0;
  logic [1:0]   step, dir;
  logic [127:0] position;
  logic         busy, buffer_empty, underflow;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  exp_t   exp_q [2][$];
  longint model_pos [2] = '{0, 0};
  int     last_step [2] = '{0, 0};
  exp_t   mon_e;

  dda_move_if #(.NUM_AXES(2), .WIDTH(64)) mv ();

  dda_move_engine #(
    .NUM_AXES(2), .BUFFER_BITS(2), .WIDTH(64), .DIV_WIDTH(8)
  ) dut (
    .CLK          (clk),
    .resetn       (resetn),
    .move_if      (mv),
    .clock_divisor(div),
    .abort        (abort),
    .step         (step),
    .dir          (dir),
    .position     (position),
    .busy         (busy),
    .buffer_empty (buffer_empty),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint pos_of(input int a);
    return position[a*64 +: 64];
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Step monitor: every pulse must match the next expected position.
  always @(negedge clk) begin
    if (resetn) begin
      for (int a = 0; a < 2; a++) begin
        if (step[a]) begin
          if (exp_q[a].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_step axis=%0d actual_pos=%0d required=no step",
                     a, pos_of(a));
          end else begin
            mon_e = exp_q[a].pop_front();
            chk($sformatf("step_position_axis%0d", a), pos_of(a), mon_e.pos);
            if (mon_e.gap > 0)
              chk($sformatf("step_gap_axis%0d", a), longint'(cyc - last_step[a]),
                  longint'(mon_e.gap));
          end
          last_step[a] = cyc;
        end
      end
    end
  end

  task automatic push_move(input logic [1:0] d, input longint dur,
                           input longint inc0, input longint inc1,
                           input int steps0, input int steps1, input int gap0,
                           output int wcyc, output int waited);
    exp_t e;
    int   n [2];
    n[0] = steps0;
    n[1] = steps1;
    for (int a = 0; a < 2; a++) begin
      for (int s = 0; s < n[a]; s++) begin
        model_pos[a] += d[a] ? 64'sd1 : -64'sd1;
        e.pos = model_pos[a];
        e.gap = (a == 0 && s > 0) ? gap0 : 0;
        exp_q[a].push_back(e);
      end
    end
    @(negedge clk);
    mv.move_valid     = 1'b1;
    mv.move_dir       = d;
    mv.move_duration  = dur;
    mv.move_increment = {inc1, inc0};
    mv.move_incinc    = '0;
    waited = 0;
    while (!mv.move_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!mv.move_ready) begin
      checks++;
      failures++;
      $display("FAIL write_timeout actual_ready=0 required=1");
    end
    @(posedge clk);
    #1;
    wcyc = cyc;
    mv.move_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int w, wt, at, d10_first, d10_cnt;
    mv.move_valid = 1'b0;
    mv.move_dir = '0;
    mv.move_duration = '0;
    mv.move_increment = '0;
    mv.move_incinc = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_position", position[63:0] | position[127:64], 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", buffer_empty, 1);
    chk("rst_ready", mv.move_ready, 1);
    chk("rst_underflow", underflow, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single segment, divisor 3: steps 4 cycles apart, busy falls after tick 5
    div = 8'd3;
    push_move(2'b01, 5, R, 0, 5, 0, 4, w, wt);
    chk("t1_empty_after_write", buffer_empty, 0);
    wait_idle(200, at);
    chk("t1_busy_fall_latency", at - w, 21);
    repeat (3) @(negedge clk);
    chk("t1_position", pos_of(0), 5);
    chk("t1_underflow", underflow, 1);

    // Two axes, opposite directions, half-rate on axis 1
    div = 8'd1;
    push_move(2'b01, 4, R, R2, 4, 2, 0, w, wt);
    wait_idle(200, at);
    repeat (3) @(negedge clk);
    chk("t2_pos_axis0", pos_of(0), 9);
    chk("t2_pos_axis1", pos_of(1), -2);
    chk("t2_dir", dir, 1);

    // Back-to-back with a zero-duration segment in between
    push_move(2'b01, 3, R, 0, 3, 0, 0, w, wt);
    push_move(2'b10, 0, R, R, 0, 0, 0, at, wt);
    push_move(2'b00, 2, R, 0, 2, 0, 0, at, wt);
    d10_first = -1;
    d10_cnt = 0;
    at = -1;
    for (int k = 0; k < 300 && at < 0; k++) begin
      @(negedge clk);
      if (dir == 2'b10) begin
        if (d10_cnt == 0) d10_first = cyc;
        d10_cnt++;
      end
      if (!busy) at = cyc;
    end
    chk("t3_zero_seg_load_offset", d10_first - w, 8);
    chk("t3_zero_seg_load_cycles", d10_cnt, 1);
    chk("t3_busy_fall_latency", at - w, 13);
    repeat (3) @(negedge clk);
    chk("t3_position", pos_of(0), 10);

    // Buffer full: 1 executing + 4 buffered, 6th write must wait
    push_move(2'b01, 1000, R, 0, 1000, 0, 0, w, wt);
    push_move(2'b00, 3, R, 0, 3, 0, 0, at, wt);
    push_move(2'b01, 2, R, 0, 2, 0, 0, at, wt);
    push_move(2'b00, 4, R, 0, 4, 0, 0, at, wt);
    push_move(2'b01, 1, R, 0, 1, 0, 0, at, wt);
    @(negedge clk);
    chk("t4_ready_when_full", mv.move_ready, 0);
    chk("t4_empty_when_full", buffer_empty, 0);
    push_move(2'b01, 5, R, 0, 5, 0, 0, at, wt);
    chk("t4_sixth_write_blocked", longint'(wt > 1000), 1);
    wait_idle(3000, at);
    repeat (3) @(negedge clk);
    chk("t4_busy_done", busy, 0);
    chk("t4_position", pos_of(0), 1011);

    // Abort mid-RUN with two segments buffered
    push_move(2'b01, 100, R, 0, 5, 0, 0, w, wt);
    push_move(2'b01, 100, R, 0, 0, 0, 0, at, wt);
    push_move(2'b01, 100, R, 0, 0, 0, 0, at, wt);
    for (int k = 0; k < 100 && pos_of(0) != 1016; k++) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_empty", buffer_empty, 1);
    chk("t5_busy", busy, 0);
    chk("t5_underflow", underflow, 0);
    chk("t5_step", step, 0);
    chk("t5_position", pos_of(0), 1016);
    repeat (20) @(negedge clk);
    chk("t5_position_held", pos_of(0), 1016);
    chk("t5_ready", mv.move_ready, 1);

    // Asynchronous reset between edges, mid-segment
    push_move(2'b01, 50, R, 0, 50, 0, 0, w, wt);
    repeat (15) @(posedge clk);
    #3 resetn = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    model_pos[0] = 0;
    model_pos[1] = 0;
    #1;
    chk("t6_step", step, 0);
    chk("t6_dir", dir, 0);
    chk("t6_pos_axis0", pos_of(0), 0);
    chk("t6_pos_axis1", pos_of(1), 0);
    chk("t6_busy", busy, 0);
    chk("t6_empty", buffer_empty, 1);
    chk("t6_ready", mv.move_ready, 1);
    chk("t6_underflow", underflow, 0);
    @(negedge clk);
    resetn = 1'b1;
    push_move(2'b01, 3, R, 0, 3, 0, 0, w, wt);
    wait_idle(200, at);
    repeat (3) @(negedge clk);
    chk("t6_post_reset_position", pos_of(0), 3);
    chk("t6_post_reset_underflow", underflow, 1);

    chk("sb_drain_axis0", exp_q[0].size(), 0);
    chk("sb_drain_axis1", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
